ula_op_sequencer: RTL
=====================

# ula_op_sequencer

Control FSM that sequences the ULA operations datapath for the stack machine. It accepts one opcode at a time from the instruction decoder and pops the operand(s) from the data stack into the operand registers. It then drives the ALU select and either pushes the result or writes the comparison flag to the comparison stack. It also reports completion and errors, and keeps a saturating count of completed operations.

## Interface

Parameters:
- SEL_WIDTH, 4, width of opcode and of SEL_ULA; the encoding equals the ULA select encoding.
- CNT_WIDTH, 16, width of OP_COUNT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset. Asynchronous, active-low: one clock; reset is asynchronous and active-low.
- OP_VALID  in  1  decoder offers an opcode.
- OP_CODE  in  SEL_WIDTH  opcode; sampled when OP_VALID && OP_READY.
- OP_READY  out  1  sequencer accepts an opcode this cycle.
- STACK_EMPTY  in  1  data stack holds no entries.
- STACK_FULL  in  1  data stack cannot accept a push.
- STACK_POP  out  1  pop top of data stack at this edge; the top value is on the operand bus this cycle.
- STACK_PUSH  out  1  push ULA_OUT at this edge.
- CTRL_REG_OP1  out  1  load operand register 1 (right operand, IN_1) from the operand bus.
- CTRL_REG_OP2  out  1  load operand register 2 (left operand, IN_2) from the operand bus.
- CTRL_REG_OVERFLOW  out  1  capture the ALU overflow flag.
- CTRL_STACK_COMP  out  1  write the compare result at the current TOS.
- SEL_ULA  out  SEL_WIDTH  ALU select.
- DONE  out  1  one-cycle pulse when an operation completes.
- ERR  out  1  one-cycle pulse when an operation aborts.
- ERR_CODE  out  2  reason, valid with ERR: 01 underflow, 10 stack full, 11 illegal opcode. Holds its value until the next ERR.
- OP_COUNT  out  CNT_WIDTH  completed (DONE) operations; saturates at all-ones.

## Operation

Opcode classes:
- Binary: 0000–0111 (ADD, SUB, MULT, LSHIFT, RSHIFT, OR, AND, XOR). Two pops, then push.
- Unary: 1000 (NOT). One pop, then push.
- Compare: 1001–1110. Two pops, then CTRL_STACK_COMP; no push.
- Illegal: 1111.

Overflow capture:
- CTRL_REG_OVERFLOW asserts in EXEC only for opcodes 0000–0100.

Operand order:
- The first pop (top of stack) loads OP1; the second pop loads OP2.
- The result is OP2 op OP1.

FSM states: IDLE, POP1, POP2, EXEC, WB.
- IDLE: OP_READY=1. On an accepted opcode:
  - latch the opcode into an internal register;
  - if illegal: ERR=1, ERR_CODE=11 in the cycle after acceptance, stay IDLE;
  - otherwise go to POP1.
- POP1:
  - if STACK_EMPTY: ERR, code 01, go to IDLE;
  - else STACK_POP=1 and CTRL_REG_OP1=1; go to EXEC if unary, else POP2.
- POP2:
  - if STACK_EMPTY: ERR, code 01, go to IDLE;
  - else STACK_POP=1 and CTRL_REG_OP2=1; go to EXEC.
- EXEC: SEL_ULA = latched opcode.
  - Compare: CTRL_STACK_COMP=1, DONE=1, go to IDLE.
  - Binary/unary: assert CTRL_REG_OVERFLOW per the class rule above; go to WB.
- WB: SEL_ULA holds the latched opcode.
  - if STACK_FULL: ERR, code 10, go to IDLE;
  - else STACK_PUSH=1, DONE=1, go to IDLE.

Signal classes:
- STACK_POP, CTRL_REG_OP1/2, STACK_PUSH and the ERR in POP1/POP2/WB are Mealy on STACK_EMPTY/STACK_FULL.
- The illegal-opcode ERR is registered: it appears in the cycle after acceptance.
- All other outputs are decoded from the state register.

Other rules:
- SEL_ULA = 1111 (no-op: ALU out 0, compare 0) in every state other than EXEC/WB.
- Pops already performed before an abort are not undone.
- OP_COUNT increments on DONE and saturates at all-ones.

## Timing

Reset (async assert, sync deassert by the system):
- state = IDLE, OP_READY = 1, SEL_ULA = 1111.
- All strobes = 0; DONE = ERR = 0; ERR_CODE = 00; OP_COUNT = 0; latched opcode = 1111.

Latency, with acceptance edge T0:

| Class | POP1 | POP2 | EXEC | WB | DONE |
|---|---|---|---|---|---|
| Binary | T0+1 | T0+2 | T0+3 | T0+4 | during WB (T0+4) |
| Unary | T0+1 | — | T0+2 | T0+3 | during WB (T0+3) |
| Compare | T0+1 | T0+2 | T0+3 | — | during EXEC (T0+3) |

Throughput and handshake:
- OP_READY is high only in IDLE, so the next opcode is accepted no earlier than the cycle after DONE/ERR.
- Back-to-back binary operations complete every 5 cycles.
- OP_VALID outside IDLE is ignored; OP_CODE need not be held after acceptance.

Simultaneous events:
- STACK_EMPTY and STACK_FULL both high in POP1: underflow wins.
- Reset mid-operation: immediate return to the reset values. No push, no compare write, and no DONE/ERR for the aborted operation.

## Test plan

- Stack [10, 3] (3 on top), SUB 0001 → OP1=3, OP2=10; WB pushes ULA_OUT=7; DONE at T0+4; overflow register loaded 0; OP_COUNT=1.
- Stack [200, 100], ADD 0000 → push 44; CTRL_REG_OVERFLOW pulsed in EXEC with overflow=1; exactly two STACK_POP pulses.
- Stack [0x0F], NOT 1000 → a single pop; push 0xF0; DONE at T0+3; no CTRL_REG_OP2 pulse.
- Stack [5, 5], EQUAL 1001 → CTRL_STACK_COMP with compare bit 1 at T0+3; no STACK_PUSH; DONE; then an immediate ADD is accepted at T0+4.
- Stack [7] with binary XOR → one pop in POP1, then ERR with ERR_CODE=01 at POP2; no DONE; OP_COUNT unchanged. Opcode 1111 → ERR code 11 one cycle after acceptance, no stack strobes.
- rst_n low during EXEC of an ADD → all outputs return to reset values asynchronously; no push after release; next opcode accepted normally.

Source files
------------

// File: rtl/ula_op_sequencer.sv
// ---------------------------------------------------------------------------
// ula_op_sequencer
//
// Control FSM for the ULA operations datapath of the stack machine. It takes
// one opcode at a time from the instruction decoder. It pops one or two
// operands off the data stack into the operand registers and drives the ALU
// select. It then pushes the result, or writes the comparison flag to the
// comparison stack. Completion and aborts are reported as one-cycle pulses,
// and a saturating counter tracks completed operations.
//
// Ports:
//   clk               system clock, rising edge
//   rst_n             asynchronous active-low reset
//   OP_VALID          decoder offers an opcode
//   OP_CODE           opcode, sampled when OP_VALID && OP_READY
//   OP_READY          sequencer accepts an opcode this cycle (IDLE only)
//   STACK_EMPTY       data stack holds no entries
//   STACK_FULL        data stack cannot accept a push
//   STACK_POP         pop top of data stack at this edge
//   STACK_PUSH        push ULA_OUT at this edge
//   CTRL_REG_OP1      load operand register 1 (right operand) from the bus
//   CTRL_REG_OP2      load operand register 2 (left operand) from the bus
//   CTRL_REG_OVERFLOW capture the ALU overflow flag
//   CTRL_STACK_COMP   write the compare result at the current TOS
//   SEL_ULA           ALU select (all-ones = no-op outside EXEC/WB)
//   DONE              one-cycle pulse on completion
//   ERR               one-cycle pulse on abort
//   ERR_CODE          01 underflow, 10 stack full, 11 illegal; held until next ERR
//   OP_COUNT          saturating count of completed operations
// ---------------------------------------------------------------------------
module ula_op_sequencer #(
    parameter int SEL_WIDTH = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 OP_VALID,
    input  logic [SEL_WIDTH-1:0] OP_CODE,
    output logic                 OP_READY,
    input  logic                 STACK_EMPTY,
    input  logic                 STACK_FULL,
    output logic                 STACK_POP,
    output logic                 STACK_PUSH,
    output logic                 CTRL_REG_OP1,
    output logic                 CTRL_REG_OP2,
    output logic                 CTRL_REG_OVERFLOW,
    output logic                 CTRL_STACK_COMP,
    output logic [SEL_WIDTH-1:0] SEL_ULA,
    output logic                 DONE,
    output logic                 ERR,
    output logic [1:0]           ERR_CODE,
    output logic [CNT_WIDTH-1:0] OP_COUNT
);

    localparam logic [SEL_WIDTH-1:0] SEL_NOP    = '1;
    localparam logic [SEL_WIDTH-1:0] OP_OVF_MAX = SEL_WIDTH'(4);
    localparam logic [SEL_WIDTH-1:0] OP_NOT     = SEL_WIDTH'(8);
    localparam logic [SEL_WIDTH-1:0] OP_CMP_MIN = SEL_WIDTH'(9);
    localparam logic [SEL_WIDTH-1:0] OP_CMP_MAX = SEL_WIDTH'(14);

    localparam logic [1:0] CODE_UNDERFLOW = 2'b01;
    localparam logic [1:0] CODE_FULL      = 2'b10;
    localparam logic [1:0] CODE_ILLEGAL   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        POP1,
        POP2,
        EXEC,
        WB
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [SEL_WIDTH-1:0]   op_q;
    logic                   ill_err_q;
    logic [1:0]             err_code_q;
    logic [CNT_WIDTH-1:0]   op_count_q;

    logic                   accept;
    logic                   op_code_illegal;
    logic                   op_is_unary;
    logic                   op_is_cmp;
    logic                   mealy_err;
    logic [1:0]             mealy_code;

    assign accept          = OP_VALID && OP_READY;
    assign op_code_illegal = (OP_CODE == SEL_NOP);
    assign op_is_unary     = (op_q == OP_NOT);
    assign op_is_cmp       = (op_q >= OP_CMP_MIN) && (op_q <= OP_CMP_MAX);

    // Next-state and output decode. Pops, pushes and the underflow/full
    // aborts react to the stack flags in the same cycle; everything else
    // follows from the state register alone.
    always_comb begin
        next_state        = state;
        OP_READY          = 1'b0;
        STACK_POP         = 1'b0;
        STACK_PUSH        = 1'b0;
        CTRL_REG_OP1      = 1'b0;
        CTRL_REG_OP2      = 1'b0;
        CTRL_REG_OVERFLOW = 1'b0;
        CTRL_STACK_COMP   = 1'b0;
        SEL_ULA           = SEL_NOP;
        DONE              = 1'b0;
        mealy_err         = 1'b0;
        mealy_code        = 2'b00;

        case (state)
            IDLE: begin
                OP_READY = 1'b1;
                if (accept && !op_code_illegal) begin
                    next_state = POP1;
                end
            end
            POP1: begin
                if (STACK_EMPTY) begin
                    mealy_err  = 1'b1;
                    mealy_code = CODE_UNDERFLOW;
                    next_state = IDLE;
                end else begin
                    STACK_POP    = 1'b1;
                    CTRL_REG_OP1 = 1'b1;
                    next_state   = op_is_unary ? EXEC : POP2;
                end
            end
            POP2: begin
                if (STACK_EMPTY) begin
                    mealy_err  = 1'b1;
                    mealy_code = CODE_UNDERFLOW;
                    next_state = IDLE;
                end else begin
                    STACK_POP    = 1'b1;
                    CTRL_REG_OP2 = 1'b1;
                    next_state   = EXEC;
                end
            end
            EXEC: begin
                SEL_ULA = op_q;
                if (op_is_cmp) begin
                    CTRL_STACK_COMP = 1'b1;
                    DONE            = 1'b1;
                    next_state      = IDLE;
                end else begin
                    // Only the arithmetic/shift group produces a meaningful
                    // overflow flag.
                    CTRL_REG_OVERFLOW = (op_q <= OP_OVF_MAX);
                    next_state        = WB;
                end
            end
            WB: begin
                SEL_ULA    = op_q;
                next_state = IDLE;
                if (STACK_FULL) begin
                    mealy_err  = 1'b1;
                    mealy_code = CODE_FULL;
                end else begin
                    STACK_PUSH = 1'b1;
                    DONE       = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // The illegal-opcode error is registered and shows up one cycle after
    // acceptance. The stack errors are combinational, so ERR_CODE bypasses
    // the held register while one of them is active.
    assign ERR      = mealy_err | ill_err_q;
    assign ERR_CODE = mealy_err ? mealy_code : err_code_q;
    assign OP_COUNT = op_count_q;

    // State register, latched opcode, held error code and completion counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_q       <= SEL_NOP;
            ill_err_q  <= 1'b0;
            err_code_q <= 2'b00;
            op_count_q <= '0;
        end else begin
            state     <= next_state;
            ill_err_q <= accept && op_code_illegal;
            if (accept) begin
                op_q <= OP_CODE;
            end
            if (accept && op_code_illegal) begin
                err_code_q <= CODE_ILLEGAL;
            end else if (mealy_err) begin
                err_code_q <= mealy_code;
            end
            if (DONE && (op_count_q != '1)) begin
                op_count_q <= op_count_q + 1'b1;
            end
        end
    end

endmodule
